// File: rtl/issue_queue.sv
// Dual-slot in-order issue queue: circular buffer between decode and issue, two pushes and two pops per cycle.
// Optional ISSUE_QUEUE_BYPASS_EN lets an empty queue forward decode inputs straight to the issue slots.
`ifndef CTRL_BUS
`define CTRL_BUS 32
`endif

module issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 in_valid_0_i,
    input  logic                 in_valid_1_i,
    input  logic [31:0]          inst0_i,
    input  logic [31:0]          inst1_i,
    input  logic [`CTRL_BUS-1:0] ctrl0_i,
    input  logic [`CTRL_BUS-1:0] ctrl1_i,
    input  logic [31:0]          pc_0_i,
    input  logic [31:0]          pc_1_i,
    input  logic                 pred_0_i,
    input  logic                 pred_1_i,
    input  logic [31:0]          pred_tgt_0_i,
    input  logic [31:0]          pred_tgt_1_i,
    output logic                 ready_o,
    input  logic                 stall_i,
    input  logic                 issue1_stall_i,
    input  logic                 flush_i,
    output logic                 out_valid_0_o,
    output logic                 out_valid_1_o,
    output logic [31:0]          out_inst0_o,
    output logic [31:0]          out_inst1_o,
    output logic [`CTRL_BUS-1:0] out_ctrl0_o,
    output logic [`CTRL_BUS-1:0] out_ctrl1_o,
    output logic [31:0]          out_pc_0_o,
    output logic [31:0]          out_pc_1_o,
    output logic                 out_pred_0_o,
    output logic                 out_pred_1_o,
    output logic [31:0]          out_pred_tgt_0_o,
    output logic [31:0]          out_pred_tgt_1_o
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CNTW   = PW + 1;
    localparam int CTRL_W = `CTRL_BUS;

    typedef struct packed {
        logic [31:0]       inst;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       pc;
        logic              pred;
        logic [31:0]       pred_tgt;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CNTW-1:0]   count_q;

    entry_t            in_e0, in_e1, cmp0, cmp1;
    entry_t            slot0, slot1, pres0, pres1, wr0, wr1;
    logic [1:0]        n_in, avail, pops, pop_st, n_wr;
    logic              bypass;

    assign in_e0 = {inst0_i, ctrl0_i, pc_0_i, pred_0_i, pred_tgt_0_i};
    assign in_e1 = {inst1_i, ctrl1_i, pc_1_i, pred_1_i, pred_tgt_1_i};
    assign n_in  = {1'b0, in_valid_0_i} + {1'b0, in_valid_1_i};

    // Depends on registered count only, so upstream sees no input-to-ready path.
    assign ready_o = (count_q <= CNTW'(DEPTH - 2));

    always_comb begin
        // A lone slot-1 instruction is compacted into the first write position.
        cmp0   = in_valid_0_i ? in_e0 : in_e1;
        cmp1   = in_e1;
        slot0  = mem[head_q];
        slot1  = mem[head_q + PW'(1)];
        avail  = (count_q >= CNTW'(2)) ? 2'd2 : count_q[1:0];
        bypass = 1'b0;
        wr0    = cmp0;
        wr1    = cmp1;
        n_wr   = (ready_o && !flush_i) ? n_in : 2'd0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (count_q == '0 && !flush_i) begin
            bypass = 1'b1;
            slot0  = cmp0;
            slot1  = cmp1;
            avail  = n_in;
        end
`endif
        if (stall_i)
            pops = 2'd0;
        else if (issue1_stall_i && avail >= 2'd1)
            pops = 2'd1;
        else
            pops = avail;
`ifdef ISSUE_QUEUE_BYPASS_EN
        // Bypassed instructions already consumed by issue never enter storage.
        if (bypass) begin
            n_wr = n_in - pops;
            if (pops == 2'd1)
                wr0 = cmp1;
        end
`endif
        pop_st = bypass ? 2'd0 : pops;
    end

    assign out_valid_0_o = (avail >= 2'd1);
    assign out_valid_1_o = (avail >= 2'd2);
    assign pres0 = out_valid_0_o ? slot0 : '0;
    assign pres1 = out_valid_1_o ? slot1 : '0;

    assign out_inst0_o      = pres0.inst;
    assign out_ctrl0_o      = pres0.ctrl;
    assign out_pc_0_o       = pres0.pc;
    assign out_pred_0_o     = pres0.pred;
    assign out_pred_tgt_0_o = pres0.pred_tgt;
    assign out_inst1_o      = pres1.inst;
    assign out_ctrl1_o      = pres1.ctrl;
    assign out_pc_1_o       = pres1.pc;
    assign out_pred_1_o     = pres1.pred;
    assign out_pred_tgt_1_o = pres1.pred_tgt;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop_st);
            tail_q  <= tail_q + PW'(n_wr);
            count_q <= count_q + CNTW'(n_wr) - CNTW'(pop_st);
        end
    end

    // Storage is left unreset; count gates every observable use of it.
    always_ff @(posedge clock_i) begin
        if (n_wr != 2'd0)
            mem[tail_q] <= wr0;
        if (n_wr == 2'd2)
            mem[tail_q + PW'(1)] <= wr1;
    end

endmodule
